// File: rtl/dfa_cmd_initiator_if.sv
// Host-side bus of the DFA command initiator: command fields, byte-level UART
// transmitter/receiver handshake and the collected ciphertext/status.
interface dfa_cmd_initiator_if;
    logic         start;
    logic         ena_fault;
    logic [7:0]   grid_mask;
    logic [31:0]  cycles;
    logic [31:0]  activecycles;
    logic [127:0] plain;
    logic [7:0]   txdataout;
    logic         txrdyout;
    logic         txrdyin;
    logic [7:0]   rxdatain;
    logic         rxrdyin;
    logic [127:0] cipher;
    logic         busy;
    logic         done;
    logic         timeout;

    modport master (
        input  start, ena_fault, grid_mask, cycles, activecycles, plain,
        input  txrdyin, rxdatain, rxrdyin,
        output txdataout, txrdyout, cipher, busy, done, timeout
    );

    modport slave (
        output start, ena_fault, grid_mask, cycles, activecycles, plain,
        output txrdyin, rxdatain, rxrdyin,
        input  txdataout, txrdyout, cipher, busy, done, timeout
    );
endinterface

// File: rtl/dfa_cmd_initiator.sv
// Sends one 26-byte DFA fault-campaign command over a byte UART and collects
// the 16-byte ciphertext reply, with a response timeout.
//
// state      | meaning
// IDLE       | waiting for start, command inputs not latched
// TX_LOAD    | transmitter idle check, strobe command byte tx_idx
// TX_WAIT_LO | waiting for transmitter to take the byte (txrdyin low)
// TX_WAIT_HI | waiting for transmitter to finish (txrdyin high)
// RX_WAIT    | collecting ciphertext bytes, timeout counter running
// DONE       | one-cycle completion pulse
module dfa_cmd_initiator #(
    parameter int TIMEOUT_CYCLES = 60000000,
    parameter int CTR_W          = 32
) (
    input logic                 clkin,
    input logic                 rstin,
    dfa_cmd_initiator_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, TX_LOAD, TX_WAIT_LO, TX_WAIT_HI, RX_WAIT, DONE
    } state_t;

    localparam logic [CTR_W-1:0] TO_LAST = CTR_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [207:0]     cmd_vec;
    logic [4:0]       tx_idx;
    logic [3:0]       rx_idx;
    logic [CTR_W-1:0] to_cnt;
    logic [1:0]       rx_edge;
    logic             rx_new;
    logic             to_hit;

    assign rx_new = (rx_edge == 2'b01);
    assign to_hit = (to_cnt == TO_LAST);

    always_ff @(posedge clkin or negedge rstin) begin
        if (!rstin) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (bus.start) state_nxt = TX_LOAD;
            TX_LOAD:    if (bus.txrdyin) state_nxt = TX_WAIT_LO;
            TX_WAIT_LO: if (!bus.txrdyin) state_nxt = TX_WAIT_HI;
            TX_WAIT_HI: begin
                if (bus.txrdyin) state_nxt = (tx_idx == 5'd25) ? RX_WAIT : TX_LOAD;
            end
            RX_WAIT: begin
                if (rx_new) begin
                    if (rx_idx == 4'd15) state_nxt = DONE;
                end else if (to_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

    // Command image is stored in wire order so byte k sits at cmd_vec[8k+:8].
    always_ff @(posedge clkin or negedge rstin) begin
        if (!rstin) begin
            cmd_vec       <= '0;
            tx_idx        <= '0;
            rx_idx        <= '0;
            to_cnt        <= '0;
            rx_edge       <= '0;
            bus.txdataout <= '0;
            bus.txrdyout  <= 1'b0;
            bus.cipher    <= '0;
            bus.timeout   <= 1'b0;
        end else begin
            rx_edge      <= {rx_edge[0], bus.rxrdyin};
            bus.txrdyout <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cmd_vec <= {bus.plain,
                                    bus.activecycles[7:0], bus.activecycles[15:8],
                                    bus.activecycles[23:16], bus.activecycles[31:24],
                                    bus.cycles[7:0], bus.cycles[15:8],
                                    bus.cycles[23:16], bus.cycles[31:24],
                                    bus.grid_mask, 7'b0, bus.ena_fault};
                        tx_idx      <= '0;
                        bus.timeout <= 1'b0;
                    end
                end
                TX_LOAD: begin
                    if (bus.txrdyin) begin
                        bus.txdataout <= cmd_vec[{tx_idx, 3'b000} +: 8];
                        bus.txrdyout  <= 1'b1;
                    end
                end
                TX_WAIT_HI: begin
                    if (bus.txrdyin) begin
                        if (tx_idx == 5'd25) begin
                            rx_idx <= '0;
                            to_cnt <= '0;
                        end else begin
                            tx_idx <= tx_idx + 5'd1;
                        end
                    end
                end
                RX_WAIT: begin
                    if (rx_new) begin
                        bus.cipher[{rx_idx, 3'b000} +: 8] <= bus.rxdatain;
                        rx_idx <= rx_idx + 4'd1;
                        to_cnt <= '0;
                    end else if (to_hit) begin
                        bus.timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + CTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dfa_cmd_initiator.sv
// Randomised bench for dfa_cmd_initiator: UART transmitter model, byte responder
// and a reference model of the command stream and ciphertext.
module tb_dfa_cmd_initiator;
    localparam int TO = 1000;

    logic clkin = 1'b0;
    logic rstin;

    dfa_cmd_initiator_if bus ();

    dfa_cmd_initiator #(.TIMEOUT_CYCLES(TO), .CTR_W(32)) dut (
        .clkin (clkin),
        .rstin (rstin),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    int n_vec = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    int strobe_cnt = 0;
    int wide_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int tx_busy_cyc = 10;
    logic txr_prev = 1'b0;
    logic [7:0] tx_log[$];
    logic [127:0] exp_cipher = '0;

    always @(posedge clkin) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clkin) begin
        txr_prev <= bus.txrdyout;
        if (bus.txrdyout && !txr_prev) strobe_cnt <= strobe_cnt + 1;
        if (bus.txrdyout && txr_prev) wide_cnt <= wide_cnt + 1;
        if (bus.done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc_cnt;
        end
    end

    // Transmitter: takes a strobed byte, goes busy for tx_busy_cyc cycles.
    initial begin
        bus.txrdyin = 1'b1;
        forever begin
            @(negedge clkin);
            if (rstin === 1'b1 && bus.txrdyout === 1'b1) begin
                tx_log.push_back(bus.txdataout);
                bus.txrdyin = 1'b0;
                repeat (tx_busy_cyc) @(negedge clkin);
                bus.txrdyin = 1'b1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cmd_byte(input logic ena, input logic [7:0] mask,
                                            input logic [31:0] cyc, input logic [31:0] act,
                                            input logic [127:0] pl, input int k);
        if (k == 0) return {7'b0, ena};
        if (k == 1) return mask;
        if (k < 6) return 8'(cyc >> (8 * (5 - k)));
        if (k < 10) return 8'(act >> (8 * (9 - k)));
        return 8'(pl >> (8 * (k - 10)));
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_rx(input logic [7:0] b, input int hold, output int rise);
        @(negedge clkin);
        bus.rxdatain = b;
        bus.rxrdyin  = 1'b1;
        rise = cyc_cnt;
        repeat (hold) @(negedge clkin);
        bus.rxrdyin = 1'b0;
        repeat (3) @(negedge clkin);
    endtask

    task automatic issue_start(input logic ena, input logic [7:0] mask, input logic [31:0] cyc,
                               input logic [31:0] act, input logic [127:0] pl);
        @(negedge clkin);
        bus.ena_fault    = ena;
        bus.grid_mask    = mask;
        bus.cycles       = cyc;
        bus.activecycles = act;
        bus.plain        = pl;
        bus.start        = 1'b1;
        @(negedge clkin);
        bus.start        = 1'b0;
        bus.ena_fault    = 1'($urandom);
        bus.grid_mask    = 8'($urandom);
        bus.cycles       = $urandom;
        bus.activecycles = $urandom;
        bus.plain        = rand128();
    endtask

    task automatic run_txn(input logic ena, input logic [7:0] mask, input logic [31:0] cyc,
                           input logic [31:0] act, input logic [127:0] pl,
                           input logic [127:0] rxword, input int n_rx, input int hold,
                           input bit stray, input bit rebusy);
        logic [7:0] exp_tx[26];
        int base_strobe;
        int base_done;
        int rise_cyc = 0;
        int dummy;
        int guard;
        bit stray_a = 0;
        bit stray_b = 0;
        bit rebusy_done = 0;
        for (int k = 0; k < 26; k++) exp_tx[k] = cmd_byte(ena, mask, cyc, act, pl, k);
        tx_log.delete();
        base_strobe = strobe_cnt;
        base_done   = done_cnt;
        issue_start(ena, mask, cyc, act, pl);
        check_val("busy_after_start", 128'(bus.busy), 128'(1));
        guard = 0;
        while (tx_log.size() < 26 && guard < 4000) begin
            @(negedge clkin);
            guard++;
            if (stray && !stray_a && tx_log.size() == 3) begin
                stray_a = 1;
                send_rx(8'($urandom), 2, dummy);
            end
            if (stray && !stray_b && tx_log.size() == 15) begin
                stray_b = 1;
                send_rx(8'($urandom), 2, dummy);
            end
            if (rebusy && !rebusy_done && tx_log.size() == 7) begin
                rebusy_done = 1;
                bus.plain = ~pl;
                bus.ena_fault = ~ena;
                bus.start = 1'b1;
                @(negedge clkin);
                bus.start = 1'b0;
            end
        end
        check_val("tx_count", 128'(tx_log.size()), 128'(26));
        for (int k = 0; k < 26; k++)
            check_val($sformatf("tx_byte%0d", k),
                      128'((k < tx_log.size()) ? tx_log[k] : 8'hxx), 128'(exp_tx[k]));
        repeat (tx_busy_cyc + 4) @(negedge clkin);
        for (int j = 0; j < n_rx; j++) begin
            send_rx(rxword[8*j +: 8], hold, rise_cyc);
            exp_cipher[8*j +: 8] = rxword[8*j +: 8];
        end
        guard = 0;
        while (done_cnt == base_done && guard < TO + 100) begin
            @(negedge clkin);
            guard++;
        end
        repeat (20) @(negedge clkin);
        check_val("done_pulses", 128'(done_cnt - base_done), 128'(1));
        check_val("done_latency", 128'(done_cyc - rise_cyc), 128'((n_rx < 16) ? TO + 2 : 2));
        check_val("timeout_flag", 128'(bus.timeout), 128'((n_rx < 16) ? 1 : 0));
        check_val("busy_after_done", 128'(bus.busy), 128'(0));
        check_val("cipher", bus.cipher, exp_cipher);
        check_val("strobes_per_txn", 128'(strobe_cnt - base_strobe), 128'(26));
    endtask

    task automatic reset_mid();
        int seen = 0;
        int guard = 0;
        int snap;
        tx_log.delete();
        issue_start(1'($urandom), 8'($urandom), $urandom, $urandom, rand128());
        while (seen < 13 && guard < 4000) begin
            @(negedge clkin);
            guard++;
            if (bus.txrdyout) seen++;
        end
        check_val("rst_strobe_reached", 128'(seen), 128'(13));
        #2 rstin = 1'b0;
        #1;
        check_val("rst_txrdyout", 128'(bus.txrdyout), 128'(0));
        check_val("rst_txdataout", 128'(bus.txdataout), 128'(0));
        check_val("rst_busy", 128'(bus.busy), 128'(0));
        check_val("rst_cipher", bus.cipher, 128'(0));
        exp_cipher = '0;
        snap = strobe_cnt;
        repeat (3) @(negedge clkin);
        rstin = 1'b1;
        repeat (100) @(negedge clkin);
        check_val("no_tx_after_rst", 128'(strobe_cnt - snap), 128'(0));
        check_val("idle_after_rst", 128'(bus.busy), 128'(0));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: observed no finish, expected finish before 80000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0]  head;
        logic [127:0] body;
        rstin            = 1'b0;
        bus.start        = 1'b0;
        bus.ena_fault    = 1'b0;
        bus.grid_mask    = '0;
        bus.cycles       = '0;
        bus.activecycles = '0;
        bus.plain        = '0;
        bus.rxdatain     = '0;
        bus.rxrdyin      = 1'b0;
        #3;
        check_val("reset_busy", 128'(bus.busy), 128'(0));
        check_val("reset_done", 128'(bus.done), 128'(0));
        check_val("reset_timeout", 128'(bus.timeout), 128'(0));
        check_val("reset_txrdyout", 128'(bus.txrdyout), 128'(0));
        check_val("reset_txdataout", 128'(bus.txdataout), 128'(0));
        check_val("reset_cipher", bus.cipher, 128'(0));
        repeat (3) @(negedge clkin);
        rstin = 1'b1;
        repeat (2) @(negedge clkin);

        run_txn(1'b1, 8'h0f, 32'h00000064, 32'h0000000a,
                128'h340737e0a29831318d305a88a8f64332,
                128'h3925841d02dc09fbdc118597196a0b32, 16, 3, 0, 0);
        head = '0;
        body = '0;
        for (int k = 0; k < 10 && k < tx_log.size(); k++) head = {head[71:0], tx_log[k]};
        for (int k = 10; k < 26 && k < tx_log.size(); k++) body = {body[119:0], tx_log[k]};
        check_val("nominal_head", 128'(head), 128'(80'h010f000000640000000a));
        check_val("nominal_plain", body, 128'h3243f6a8885a308d313198a2e0370734);
        check_val("nominal_cipher_literal", bus.cipher, 128'h3925841d02dc09fbdc118597196a0b32);

        run_txn(1'($urandom), 8'($urandom), $urandom, $urandom, rand128(), rand128(), 5, 3, 0, 0);

        tx_busy_cyc = 50;
        run_txn(1'($urandom), 8'($urandom), $urandom, $urandom, rand128(), rand128(), 16, 20, 0, 0);
        check_val("strobe_width", 128'(wide_cnt), 128'(0));
        tx_busy_cyc = 10;

        run_txn(1'($urandom), 8'($urandom), $urandom, $urandom, rand128(), rand128(), 16, 2, 1, 1);

        reset_mid();
        run_txn(1'b1, 8'($urandom), $urandom, $urandom, rand128(), rand128(), 16, 3, 0, 0);

        for (int n = 0; n < 3; n++) begin
            tx_busy_cyc = int'($urandom_range(3, 15));
            run_txn(1'($urandom), 8'($urandom), $urandom, $urandom, rand128(), rand128(),
                    16, int'($urandom_range(1, 6)), 1'($urandom), 0);
        end
        check_val("strobe_width_final", 128'(wide_cnt), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
